mux_n_stream: RTL and testbench
===============================

MUX_N_STREAM -- requirements
Module: mux_n_stream

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: data width per channel.
REQ-003 SHALL derive local SEL_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-006 SHALL have port mode input 1: 0 = direct select, 1 = round-robin.
REQ-007 SHALL have port sel input SEL_W: channel index, used only in direct mode.
REQ-008 SHALL have port in_data input NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid input NUM_CH: per-channel valid.
REQ-010 SHALL have port in_ready output NUM_CH: per-channel ready, at most one bit set.
REQ-011 SHALL have port out_data output WIDTH: registered selected data.
REQ-012 SHALL have port out_ch output SEL_W: index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid output 1: out_data/out_ch hold a valid word.
REQ-014 SHALL have port out_ready input 1: downstream accepts the word when out_valid=1.

Function
REQ-015 SHALL compute load = !out_valid || out_ready, combinationally each cycle.
REQ-016 Direct mode SHALL grant channel sel iff sel < NUM_CH and in_valid[sel]=1; otherwise no grant.
REQ-017 Direct mode SHALL NOT grant any other channel, even if it is valid.
REQ-018 Round-robin mode SHALL grant the first channel with in_valid=1, searching from internal pointer ptr upward and wrapping from NUM_CH-1 to 0.
REQ-019 SHALL grant no channel when in_valid is all zero.
REQ-020 SHALL drive in_ready[i] = load && grant[i], combinationally; in_ready SHALL be all zero whenever load=0.
REQ-021 A transfer SHALL occur in a cycle with load=1 and a grant.
REQ-022 On a transfer, the next edge SHALL register out_data = granted channel data, out_ch = granted index and out_valid = 1, giving latency 1 cycle.
REQ-023 When load=1 and there is no grant, the next edge SHALL clear out_valid to 0 and leave out_data/out_ch unchanged.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL stay stable.
REQ-025 On a round-robin transfer, ptr SHALL become (granted index + 1) mod NUM_CH.
REQ-026 ptr SHALL be unchanged in cycles with no transfer and in all direct-mode cycles.
REQ-027 A change of mode SHALL take effect in the same cycle, and ptr SHALL be retained across the change.
REQ-028 Back-to-back transfers SHALL sustain one word per cycle while out_ready=1 and a grant exists.
REQ-029 A word presented on the outputs SHALL be consumed exactly once: not dropped and not duplicated.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_ch=0 and ptr=0.
REQ-031 While rst=1, in_ready SHALL be all zero regardless of in_valid.
REQ-032 Reset asserted mid-transfer SHALL discard the held word; no transfer SHALL be recorded in that cycle.
REQ-033 In the first cycle after rst deasserts, round-robin search SHALL start at channel 0.

Verification (NUM_CH=4, WIDTH=8 unless stated)
REQ-034 Reset: rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=4'b0000, out_valid=0, out_data=8'h00, out_ch=0.
REQ-035 Direct: mode=0, sel=2, in_valid=4'b0110, ch2 data 8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-036 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 held -> successive out_ch values 0,1,2,3,0,1.
REQ-037 Wrap and skip: ptr=2 (after a ch1 grant), in_valid=4'b0011 -> ch0 granted, ptr becomes 1.
REQ-038 Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 3 cycles -> outputs stable, in_ready=4'b0000; raising out_ready -> next granted word appears 1 cycle later.
REQ-039 Out-of-range select: NUM_CH=3, mode=0, sel=3, in_valid=3'b111 -> in_ready=3'b000, out_valid falls to 0 once drained.

Source files
------------

// File: rtl/mux_n_stream.sv
// N-channel valid/ready stream multiplexer with direct or round-robin selection
// and a single registered output slot.
module mux_n_stream #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             xfer;
    logic             gnt_hit;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W:0]   sum;
    logic [SEL_W:0]   nxt;

    assign load = !valid_q || out_ready;
    assign xfer = load && gnt_hit && !rst;

    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        if (mode) begin
            // Search upward from ptr, wrapping at NUM_CH
            for (int k = 0; k < NUM_CH; k++) begin
                sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (sum >= (SEL_W+1)'(NUM_CH)) begin
                    sum = sum - (SEL_W+1)'(NUM_CH);
                end
                if (!gnt_hit && in_valid[sum[SEL_W-1:0]]) begin
                    gnt_hit = 1'b1;
                    gnt_idx = sum[SEL_W-1:0];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_hit = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_ready[i] = (gnt_idx == SEL_W'(i));
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        nxt     = {1'b0, gnt_idx} + (SEL_W+1)'(1);
        if (load) begin
            valid_d = gnt_hit;
        end
        if (xfer) begin
            data_d = gnt_data;
            ch_d   = gnt_idx;
            if (mode) begin
                ptr_d = (nxt == (SEL_W+1)'(NUM_CH)) ? '0 : nxt[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: directed vector table, randomized run against a
// queue-free arithmetic model, and a 3-channel out-of-range select sequence.
module tb_mux_n_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, out_ready, out_valid;
    logic [1:0]  sel, out_ch;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;

    logic        rst3, mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_ch3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;

    mux_n_stream #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_n_stream #(.NUM_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_ch;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic md, logic [1:0] s,
                                logic [3:0] v, logic [31:0] d, logic o,
                                logic [3:0] er, logic eov, logic [7:0] eod,
                                logic [1:0] ech);
        vec_t t;
        t.name = n; t.rst = r; t.mode = md; t.sel = s; t.vld = v;
        t.data = d; t.ordy = o; t.e_rdy = er; t.e_ov = eov;
        t.e_od = eod; t.e_ch = ech;
        return t;
    endfunction

    // Reference model state
    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;

    function automatic int mgrant(logic md, logic [1:0] s, logic [3:0] v,
                                  int p);
        if (!md) return v[s] ? int'(s) : -1;
        for (int k = 0; k < 4; k++) begin
            int c = (p + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    localparam logic [31:0] D1 = 32'h44A52211;
    localparam logic [31:0] D2 = 32'h3CA52211;

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = D1;
        in_valid = 4'b0; out_ready = 1'b1;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h332211;
        in_valid3 = 3'b111; out_ready3 = 1'b1;

        vecs.push_back(mk("rst0", 1, 1, 0, 4'b1111, D1, 1, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk("rst1", 1, 1, 0, 4'b1111, D1, 1, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk("dir2", 0, 0, 2, 4'b0110, D1, 1, 4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk("dirnone", 0, 0, 2, 4'b0000, D1, 1, 4'b0000, 0, 8'hA5, 2));
        vecs.push_back(mk("rr0", 0, 1, 0, 4'b1111, D1, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk("rr1", 0, 1, 0, 4'b1111, D1, 1, 4'b0010, 1, 8'h22, 1));
        vecs.push_back(mk("rr2", 0, 1, 0, 4'b1111, D1, 1, 4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk("rr3", 0, 1, 0, 4'b1111, D1, 1, 4'b1000, 1, 8'h44, 3));
        vecs.push_back(mk("rr4", 0, 1, 0, 4'b1111, D1, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk("rr5", 0, 1, 0, 4'b1111, D1, 1, 4'b0010, 1, 8'h22, 1));
        vecs.push_back(mk("wrap", 0, 1, 0, 4'b0011, D1, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk("ptr1", 0, 1, 0, 4'b0011, D1, 1, 4'b0010, 1, 8'h22, 1));
        vecs.push_back(mk("ld3c", 0, 0, 3, 4'b1000, D2, 1, 4'b1000, 1, 8'h3C, 3));
        vecs.push_back(mk("bp0", 0, 1, 0, 4'b1111, D2, 0, 4'b0000, 1, 8'h3C, 3));
        vecs.push_back(mk("bp1", 0, 1, 0, 4'b1111, D2, 0, 4'b0000, 1, 8'h3C, 3));
        vecs.push_back(mk("bp2", 0, 1, 0, 4'b1111, D2, 0, 4'b0000, 1, 8'h3C, 3));
        vecs.push_back(mk("bprel", 0, 1, 0, 4'b1111, D2, 1, 4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk("mdir", 0, 0, 1, 4'b1111, D2, 1, 4'b0010, 1, 8'h22, 1));
        vecs.push_back(mk("mrr", 0, 1, 0, 4'b1111, D2, 1, 4'b1000, 1, 8'h3C, 3));
        vecs.push_back(mk("mrr2", 0, 1, 0, 4'b1111, D2, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk("rstmid", 1, 1, 0, 4'b1111, D2, 1, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk("post", 0, 1, 0, 4'b1111, D2, 1, 4'b0001, 1, 8'h11, 0));
        vecs.push_back(mk("hold", 0, 1, 0, 4'b0000, D2, 0, 4'b0000, 1, 8'h11, 0));
        vecs.push_back(mk("drain", 0, 1, 0, 4'b0000, D2, 1, 4'b0000, 0, 8'h11, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
            in_valid = vecs[i].vld; in_data = vecs[i].data;
            out_ready = vecs[i].ordy;
            #3;
            chk({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'(vecs[i].e_rdy));
            if (i == 0) chk("rst3.in_ready", 32'(in_ready3), 32'd0);
            @(posedge clk); #1;
            chk({vecs[i].name, ".out_valid"}, 32'(out_valid), 32'(vecs[i].e_ov));
            chk({vecs[i].name, ".out_data"}, 32'(out_data), 32'(vecs[i].e_od));
            chk({vecs[i].name, ".out_ch"}, 32'(out_ch), 32'(vecs[i].e_ch));
        end

        m_valid = 1'b0; m_data = 8'h11; m_ch = 0; m_ptr = 1;
        for (int n = 0; n < 400; n++) begin
            int g;
            logic ld;
            logic [3:0] er;
            rst = ($urandom_range(0, 39) == 0);
            mode = 1'($urandom);
            sel = 2'($urandom);
            in_valid = 4'($urandom);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            g = mgrant(mode, sel, in_valid, m_ptr);
            ld = !m_valid || out_ready;
            er = (rst || !ld || g < 0) ? 4'b0 : 4'(1 << g);
            chk("rand.in_ready", 32'(in_ready), 32'(er));
            @(posedge clk);
            if (rst) begin
                m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    m_valid = 1;
                    m_data = in_data[g*8 +: 8];
                    m_ch = g;
                    if (mode) m_ptr = (g + 1) % 4;
                end else begin
                    m_valid = 0;
                end
            end
            #1;
            chk("rand.out_valid", 32'(out_valid), 32'(m_valid));
            chk("rand.out_data", 32'(out_data), 32'(m_data));
            chk("rand.out_ch", 32'(out_ch), 32'(m_ch));
        end

        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111;
        #3 chk("n3.sel0.in_ready", 32'(in_ready3), 32'b001);
        @(posedge clk); #1;
        chk("n3.sel0.out_valid", 32'(out_valid3), 32'd1);
        chk("n3.sel0.out_data", 32'(out_data3), 32'h11);
        sel3 = 2'd3;
        #3 chk("n3.sel3.in_ready", 32'(in_ready3), 32'b000);
        @(posedge clk); #1;
        chk("n3.sel3.out_valid", 32'(out_valid3), 32'd0);
        chk("n3.sel3.out_ch", 32'(out_ch3), 32'd0);
        mode3 = 1'b1; in_valid3 = 3'b100;
        #3 chk("n3.rr2.in_ready", 32'(in_ready3), 32'b100);
        @(posedge clk); #1;
        chk("n3.rr2.out_data", 32'(out_data3), 32'h33);
        chk("n3.rr2.out_ch", 32'(out_ch3), 32'd2);
        in_valid3 = 3'b111;
        #3 chk("n3.wrap.in_ready", 32'(in_ready3), 32'b001);
        @(posedge clk); #1;
        chk("n3.wrap.out_ch", 32'(out_ch3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
